// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default constants and parity helper.
// Used by both the transmit core and the receive deserialiser.
package uart_pkg;

  localparam int UART_DEF_DATA_WIDTH = 8;
  localparam int UART_DEF_BAUD_DIV   = 868;
  localparam int UART_MAX_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Even parity over the (zero-extended) data word, flipped for odd sense.
  function automatic logic uart_parity(input logic [UART_MAX_DATA_WIDTH-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// Byte handshake between the transmit buffer (master) and the UART TX core (slave).
interface uart_tx_core_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DEF_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] data_i;
  logic                  valid_in;
  logic                  ready_in;

  modport master (output data_i, output valid_in, input ready_in);
  modport slave  (input data_i, input valid_in, output ready_in);

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BAUD_DIV-1 and pulses bit_end on the last cycle.
// Held at zero while clear is high so the first bit after clear is a full period.
module uart_baud_cnt #(
  parameter int BAUD_DIV = 868
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  assign bit_end = ~clear & (cnt_reg == LAST);

  always_comb begin
    cnt_next = cnt_reg + CW'(1);
    if (clear || bit_end) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmit engine: start bit, LSB-first data, optional parity, stop bits.
// Parity bit is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DEF_DATA_WIDTH,
  parameter int BAUD_DIV   = UART_DEF_BAUD_DIV,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rstn,
  uart_tx_core_if.slave     tx_if,
  output logic              tx_o,
  output logic              busy_o
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  if (DATA_WIDTH < 5 || DATA_WIDTH > UART_MAX_DATA_WIDTH || BAUD_DIV < 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || (PARITY_ODD != 0 && PARITY_ODD != 1))
  begin : g_bad_cfg
    $error("uart_tx_core: unsupported parameter set");
  end

  uart_state_t           state_reg, state_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [BW-1:0]         bit_cnt_reg, bit_cnt_next;
  logic                  tx_reg, tx_next;
  logic                  bit_end;
  logic                  accept;
`ifdef UART_TX_PARITY_EN
  logic                  parity_reg, parity_next;
`endif

  assign tx_if.ready_in = (state_reg == ST_IDLE);
  assign busy_o         = (state_reg != ST_IDLE);
  assign accept         = tx_if.valid_in & tx_if.ready_in;
  assign tx_o           = tx_reg;

  uart_baud_cnt #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (state_reg == ST_IDLE),
    .bit_end (bit_end)
  );

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next   = ST_START;
          shift_next   = tx_if.data_i;
          bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
          parity_next  = uart_parity(UART_MAX_DATA_WIDTH'(tx_if.data_i), 1'(PARITY_ODD));
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_next   = ST_DATA;
          bit_cnt_next = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt_reg == LAST_DATA) begin
            bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next   = ST_PARITY;
`else
            state_next   = ST_STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_next   = ST_STOP;
          bit_cnt_next = '0;
        end
      end
`endif
      ST_STOP: begin
        // bit_cnt is reused to count stop bits
        if (bit_end) begin
          if (bit_cnt_reg == LAST_STOP) begin
            state_next   = ST_IDLE;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + BW'(1);
          end
        end
      end
      default: begin
        state_next   = ST_IDLE;
        bit_cnt_next = '0;
      end
    endcase
  end

  // Line value is registered from the upcoming state so it is valid from its first cycle.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next = parity_next;
`endif
      default:   tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      tx_reg      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      tx_reg      <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core (BAUD_DIV=4, DATA_WIDTH=8); expected frames adapt to
// UART_TX_PARITY_EN. dut0: STOP_BITS=1, even parity; dut1: STOP_BITS=2, odd parity.
module tb_uart_tx_core;
  import uart_pkg::*;

  localparam int B  = 4;
  localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam int N0 = 11;
`else
  localparam int N0 = 10;
`endif

  typedef struct {
    int          dut;
    logic [7:0]  data;
    int          nbits;
    logic [15:0] line;   // bit j = line level during bit time j
    bit          hold;
    logic [7:0]  nxt;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  logic tx0, busy0, tx1, busy1;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  bit   rx_en = 1'b0;
  logic [7:0] rx_q[$];
  int         rx_t[$];
  vec_t vecs[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_core_if #(.DATA_WIDTH(DW)) if0 ();
  uart_tx_core_if #(.DATA_WIDTH(DW)) if1 ();

  uart_tx_core #(.DATA_WIDTH(DW), .BAUD_DIV(B), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rstn(rstn), .tx_if(if0), .tx_o(tx0), .busy_o(busy0));
  uart_tx_core #(.DATA_WIDTH(DW), .BAUD_DIV(B), .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
    .clk(clk), .rstn(rstn), .tx_if(if1), .tx_o(tx1), .busy_o(busy1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [7:0] x);
    if (d == 0) begin
      if0.valid_in = v; if0.data_i = x;
    end else begin
      if1.valid_in = v; if1.data_i = x;
    end
  endtask

  function automatic logic [2:0] status(input int d);
    return (d == 0) ? {if0.ready_in, busy0, tx0} : {if1.ready_in, busy1, tx1};
  endfunction

  // Called at a negedge; accepts one byte and checks every cycle of its frame.
  task automatic run_frame(input vec_t v);
    int len, tx_errs, hs_errs, j;
    logic [15:0] obs;
    logic [2:0] st;
    len = v.nbits * B; tx_errs = 0; hs_errs = 0; obs = '0;
    drive(v.dut, 1'b1, v.data);
    @(posedge clk);
    @(negedge clk);
    if (v.hold) drive(v.dut, 1'b1, v.nxt);
    else        drive(v.dut, 1'b0, 8'h00);
    for (int k = 1; k <= len; k++) begin
      st = status(v.dut);
      j = (k - 1) / B;
      if (st[0] !== v.line[j]) tx_errs++;
      if ((k - 1) % B == B / 2) obs[j] = st[0];
      if (st[2:1] !== 2'b01) hs_errs++;
      if (v.hold && k == len / 2)  drive(v.dut, 1'b1, ~v.nxt);
      if (v.hold && k == len - 1)  drive(v.dut, 1'b1, v.nxt);
      @(negedge clk);
    end
    check($sformatf("frame_%02h_line", v.data), {16'h0, obs}, {16'h0, v.line});
    check($sformatf("frame_%02h_tx_cycle_errs", v.data), tx_errs, 0);
    check($sformatf("frame_%02h_busy_ready_errs", v.data), hs_errs, 0);
    check($sformatf("frame_%02h_end_rdy_busy_tx", v.data), {29'h0, status(v.dut)}, 32'h5);
    $display("[TB] dut%0d byte 0x%02h: line=0x%03h expected=0x%03h len=%0d",
             v.dut, v.data, obs, v.line, len);
  endtask

  // Loopback receiver on dut0: samples mid-bit, records frame start cycle.
  initial begin : rx_model
    int c0;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rx_en && tx0 === 1'b0) begin
        c0 = cyc;
        b = '0;
        repeat (B + B / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          b[i] = tx0;
          if (i < 7) repeat (B) @(negedge clk);
        end
        repeat (N0 * B - 1 - (B + B / 2) - 7 * B) @(negedge clk);
        rx_q.push_back(b);
        rx_t.push_back(c0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t rv;
    int w;
`ifdef UART_TX_PARITY_EN
    vecs[0] = '{0, 8'hA5, 11, 16'h054A, 1'b1, 8'h3C};
    vecs[1] = '{0, 8'h3C, 11, 16'h0478, 1'b0, 8'h00};
    vecs[2] = '{1, 8'hFF, 12, 16'h0FFE, 1'b0, 8'h00};
    vecs[3] = '{0, 8'h07, 11, 16'h060E, 1'b0, 8'h00};
    vecs[4] = '{1, 8'h07, 12, 16'h0C0E, 1'b0, 8'h00};
    vecs[5] = '{0, 8'h00, 11, 16'h0400, 1'b0, 8'h00};
    rv      = '{0, 8'h55, 11, 16'h04AA, 1'b0, 8'h00};
`else
    vecs[0] = '{0, 8'hA5, 10, 16'h034A, 1'b1, 8'h3C};
    vecs[1] = '{0, 8'h3C, 10, 16'h0278, 1'b0, 8'h00};
    vecs[2] = '{1, 8'hFF, 11, 16'h07FE, 1'b0, 8'h00};
    vecs[3] = '{0, 8'h07, 10, 16'h020E, 1'b0, 8'h00};
    vecs[4] = '{1, 8'h07, 11, 16'h060E, 1'b0, 8'h00};
    vecs[5] = '{0, 8'h00, 10, 16'h0200, 1'b0, 8'h00};
    rv      = '{0, 8'h55, 10, 16'h02AA, 1'b0, 8'h00};
`endif
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #2;
    check("reset_dut0_rdy_busy_tx", {29'h0, status(0)}, 32'h5);
    check("reset_dut1_rdy_busy_tx", {29'h0, status(1)}, 32'h5);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_dut0_idle", {29'h0, status(0)}, 32'h5);

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // Reset during the third data bit of 0xF0 (that bit is 0 on the line)
    drive(0, 1'b1, 8'hF0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    repeat (13) @(negedge clk);
    check("midframe_pre_reset_tx", {31'h0, tx0}, 32'h0);
    #2 rstn = 1'b0;
    #1;
    check("midframe_reset_rdy_busy_tx", {29'h0, status(0)}, 32'h5);
    $display("[TB] reset asserted mid-frame: status=%03b", status(0));
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_frame(rv);

    // Continuous stream with valid held high
    rx_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(0, 1'b1, 8'(i));
      w = 0;
      while (!if0.ready_in && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (w >= 200) check($sformatf("stream_%0d_ready_timeout", i), 32'(w), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    drive(0, 1'b0, 8'h00);
    w = 0;
    while (rx_q.size() < 16 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("stream_rx_count", 32'(rx_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      check($sformatf("stream_%0d_rx_byte", i), {24'h0, rx_q[i]}, 32'(i));
      if (i > 0)
        check($sformatf("stream_%0d_spacing", i), 32'(rx_t[i] - rx_t[i-1]), 32'(N0 * B + 1));
      $display("[TB] stream frame %0d: rx=0x%02h start_cycle=%0d", i, rx_q[i], rx_t[i]);
    end
    rx_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
